serial_adder: RTL and testbench
===============================

SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand and result width in bits; legal range 2..32.
REQ-002 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 start  input  1  request to begin an addition; sampled on rising clk.
REQ-006 a  input  WIDTH  operand A; captured in the start cycle only.
REQ-007 b  input  WIDTH  operand B; captured in the start cycle only.
REQ-008 cin  input  1  carry-in; captured in the start cycle only.
REQ-009 busy  output  1  high while an addition is in progress (RUN or DONE state).
REQ-010 done  output  1  one-cycle pulse marking sum/cout valid.
REQ-011 sum  output  WIDTH  registered result a+b+cin, modulo 2^WIDTH.
REQ-012 cout  output  1  registered carry-out of the WIDTH-bit addition.

Function
REQ-013 The block SHALL add bit-serially, LSB first, one bit per clock, with one full-adder cell and a carry flip-flop; no WIDTH-bit parallel adder.
REQ-014 The FSM SHALL have exactly the states IDLE, RUN and DONE.
REQ-015 IDLE: start=1 at a rising edge -> load A/B shift registers with a/b, carry FF with cin, bit counter 0, result shift register cleared; next state RUN.
REQ-016 IDLE with start=0 SHALL stay in IDLE with no register changes.
REQ-017 RUN, each edge: bit = A[0]^B[0]^carry; carry <= majority(A[0],B[0],carry); bit shifted into result MSB (result shifts right); A and B shift right; counter +1.
REQ-018 RUN SHALL last exactly WIDTH cycles; on the edge that processes counter=WIDTH-1 -> sum <= completed result, cout <= final carry, next state DONE.
REQ-019 DONE SHALL last one cycle with done=1; next state IDLE.
REQ-020 Latency: done SHALL be high in the cycle following the (WIDTH+1)-th rising edge after, and counting, the edge sampling start.
REQ-021 start in RUN or DONE SHALL be ignored; the in-flight operation and a/b/cin captured earlier SHALL be unaffected.
REQ-022 Back-to-back: start asserted in the first IDLE cycle after DONE SHALL be accepted; no extra dead cycles beyond the single IDLE cycle.
REQ-023 sum and cout SHALL change only on the RUN->DONE edge and SHALL hold the last result through later IDLE and RUN periods until the next completion.
REQ-024 Changes on a, b, cin after the start cycle SHALL NOT affect the result.
REQ-025 busy SHALL be 1 in RUN and DONE, 0 in IDLE; done SHALL be 1 only in DONE.
REQ-026 The bit counter SHALL be ceil(log2(WIDTH+1)) bits wide and SHALL never wrap during an operation.

Reset
REQ-027 rst_n=0 SHALL, without waiting for clk, force state IDLE, busy=0, done=0, sum=0, cout=0, and clear the carry FF, counter, and all shift registers.
REQ-028 Reset asserted mid-RUN or in DONE SHALL abort the operation; no done pulse for it after release.
REQ-029 After rst_n deasserts, the first rising edge with start=1 SHALL be accepted as in REQ-015.

Verification
REQ-030 WIDTH=8, a=0x00, b=0x00, cin=0, start 1 cycle -> done pulse exactly per REQ-020, sum=0x00, cout=0.
REQ-031 a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1; a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1.
REQ-032 a=0x5A, b=0x3C, cin=0 -> sum=0x96, cout=0; change a/b to 0xFF during RUN and pulse start again -> same result, one done pulse only.
REQ-033 Start 0x12+0x34, assert rst_n=0 at counter=4 -> sum=0x00, cout=0, busy=0 immediately, no done; then 0x12+0x34+1 -> sum=0x47, cout=0.
REQ-034 Back-to-back starts in every legal IDLE cycle, 1000 random a/b/cin -> each {cout,sum} equals a+b+cin; sum/cout stable between done pulses.

Source files
------------

// File: rtl/serial_adder_if.sv
// Handshake/data bundle for serial_adder.
//   start      : request to begin an addition (sampled on rising clk)
//   a, b, cin  : operands and carry-in, captured in the start cycle only
//   busy       : high while an addition is in progress
//   done       : one-cycle pulse marking sum/cout valid
//   sum, cout  : registered result and carry-out
// master drives the request side, slave is the adder.
interface serial_adder_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (
    output start, a, b, cin,
    input  busy, done, sum, cout
  );

  modport slave (
    input  start, a, b, cin,
    output busy, done, sum, cout
  );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell plus a carry flip-flop, LSB first,
// one bit per clock. WIDTH cycles of RUN, then a one-cycle DONE pulse.
//   clk   : rising-edge clock for all state
//   rst_n : asynchronous active-low reset
//   bus   : serial_adder_if slave (start/a/b/cin in, busy/done/sum/cout out)
// WIDTH legal range is 2..32.
module serial_adder #(
  parameter int unsigned WIDTH = 8
) (
  input logic           clk,
  input logic           rst_n,
  serial_adder_if.slave bus
);

  localparam int unsigned     CntW    = $clog2(WIDTH + 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;

  logic             fa_bit;
  logic             fa_carry;
  logic [WIDTH-1:0] res_shift;

  // The single full-adder cell.
  assign fa_bit    = a_q[0] ^ b_q[0] ^ carry_q;
  assign fa_carry  = (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);
  // New bit enters at the MSB so after WIDTH shifts the LSB sits at bit 0.
  assign res_shift = {fa_bit, res_q[WIDTH-1:1]};

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    cout_d  = cout_q;

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          a_d     = bus.a;
          b_d     = bus.b;
          carry_d = bus.cin;
          cnt_d   = '0;
          res_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        carry_d = fa_carry;
        res_d   = res_shift;
        cnt_d   = cnt_q + CntW'(1);
        if (cnt_q == LastCnt) begin
          sum_d   = res_shift;
          cout_d  = fa_carry;
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
    end
  end

  // Decoded straight from the state register so reset clears them at once.
  assign bus.busy = (state_q != StIdle);
  assign bus.done = (state_q == StDone);
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder (WIDTH=8). Inputs are driven 1 time unit
// after a rising edge; outputs are sampled at that same offset.
module tb_serial_adder;

  localparam int unsigned W       = 8;
  localparam int          LatEdge = W + 1;  // edges from start edge to done

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;

  serial_adder_if #(.WIDTH(W)) bus ();

  serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called 1 unit after an edge while IDLE; returns 1 unit after the start edge.
  task automatic start_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic ci);
    bus.a     = av;
    bus.b     = bv;
    bus.cin   = ci;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
  endtask

  // Waits for done with a cycle bound; e0 edges already elapsed since (and
  // counting) the start edge. Flags any change of sum/cout before done.
  task automatic wait_done(input int e0, input logic [W:0] prev, output int edges,
                           output logic stable);
    edges  = e0;
    stable = 1'b1;
    while (!bus.done && edges < 40) begin
      if ({bus.cout, bus.sum} !== prev) stable = 1'b0;
      step();
      edges++;
    end
  endtask

  // Full op from IDLE: latency, result, single pulse, return to IDLE.
  task automatic run_op(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic ci, input logic [W:0] prev, input logic [W:0] exp);
    int   edges;
    logic stable;
    start_op(av, bv, ci);
    check({tag, ".busy_run"}, 32'(bus.busy), 32'd1);
    wait_done(1, prev, edges, stable);
    check({tag, ".latency"}, 32'(edges), 32'(LatEdge));
    check({tag, ".hold"}, 32'(stable), 32'd1);
    check({tag, ".result"}, 32'({bus.cout, bus.sum}), 32'(exp));
    check({tag, ".busy_done"}, 32'(bus.busy), 32'd1);
    step();
    check({tag, ".pulse"}, 32'({bus.done, bus.busy}), 32'd0);
  endtask

  task automatic watch_no_done(input string tag, input int cycles);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      if (bus.done) seen = 1'b1;
      step();
    end
    check(tag, 32'(seen), 32'd0);
  endtask

  initial begin
    int          edges;
    logic        stable;
    logic [W:0]  prev;
    logic [W:0]  exp;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic        rc;

    n_vec     = 0;
    n_err     = 0;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    bus.cin   = 1'b0;

    #3;
    check("reset.outs", 32'({bus.busy, bus.done, bus.cout, bus.sum}), 32'd0);
    step();
    step();
    rst_n = 1'b1;
    step();
    check("reset.idle", 32'({bus.busy, bus.done}), 32'd0);

    // 0 + 0 + 0
    run_op("zero", 8'h00, 8'h00, 1'b0, 9'h000, 9'h000);
    // Wrap cases
    run_op("ff_01", 8'hFF, 8'h01, 1'b0, 9'h000, 9'h100);
    step();
    run_op("ff_ff_1", 8'hFF, 8'hFF, 1'b1, 9'h100, 9'h1FF);
    step();

    // Operand change plus a second start mid-RUN must be ignored.
    start_op(8'h5A, 8'h3C, 1'b0);
    step();
    step();
    check("ign.hold_prev", 32'({bus.cout, bus.sum}), 32'h1FF);
    bus.a     = 8'hFF;
    bus.b     = 8'hFF;
    bus.cin   = 1'b1;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    wait_done(4, 9'h1FF, edges, stable);
    check("ign.latency", 32'(edges), 32'(LatEdge));
    check("ign.hold", 32'(stable), 32'd1);
    check("ign.result", 32'({bus.cout, bus.sum}), 32'h096);
    step();
    watch_no_done("ign.single_pulse", 14);
    check("ign.idle", 32'(bus.busy), 32'd0);

    // Reset while counter = 4 aborts; outputs clear without a clock edge.
    start_op(8'h12, 8'h34, 1'b0);
    step();
    step();
    step();
    step();
    check("abort.busy_before", 32'(bus.busy), 32'd1);
    rst_n = 1'b0;
    #2;
    check("abort.outs", 32'({bus.busy, bus.done, bus.cout, bus.sum}), 32'd0);
    step();
    step();
    rst_n = 1'b1;
    step();
    watch_no_done("abort.no_done", 14);
    run_op("after_rst", 8'h12, 8'h34, 1'b1, 9'h000, 9'h047);

    // Back-to-back: start in the first IDLE cycle after every done.
    prev = 9'h047;
    for (int i = 0; i < 1000; i++) begin
      ra   = W'($urandom);
      rb   = W'($urandom);
      rc   = 1'($urandom);
      exp  = {1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rc};
      start_op(ra, rb, rc);
      wait_done(1, prev, edges, stable);
      check("b2b.latency", 32'(edges), 32'(LatEdge));
      check("b2b.hold", 32'(stable), 32'd1);
      check("b2b.result", 32'({bus.cout, bus.sum}), 32'(exp));
      step();
      check("b2b.idle", 32'({bus.done, bus.busy}), 32'd0);
      prev = exp;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
